// File: rtl/button_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_scheduler
//  Description : Turns debounced button levels into a single serialized stream
//                of press / auto-repeat / release events. Each button runs its
//                own hold/repeat state machine and latches pending events.
//                One valid/ready event port is shared among all buttons using
//                round-robin arbitration.
//
//  Ports
//    clk        : system clock, rising edge
//    rst        : synchronous active-high reset
//    btn_level  : debounced button levels, 1 = pressed
//    repeat_en  : per-button auto-repeat enable
//    evt_valid  : event available on evt_id / evt_kind
//    evt_ready  : consumer accepts the event this cycle
//    evt_id     : index of the button the event belongs to
//    evt_kind   : 00 press, 01 repeat, 10 release
//    overflow   : sticky, a pending event was set while already pending
//
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_scheduler #(
    parameter int NUM_BTN       = 5,
    parameter int ID_WIDTH      = 3,
    parameter int CNT_WIDTH     = 27,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   btn_level,
    input  logic [NUM_BTN-1:0]   repeat_en,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [ID_WIDTH-1:0]  evt_id,
    output logic [1:0]           evt_kind,
    output logic                 overflow
);

    localparam logic [CNT_WIDTH-1:0] c_HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);
    localparam int                   c_SCAN_W    = ID_WIDTH + 1;
    localparam logic [c_SCAN_W-1:0]  c_NUM_EXT   = c_SCAN_W'(NUM_BTN);
    localparam logic [ID_WIDTH-1:0]  c_LAST_ID   = ID_WIDTH'(NUM_BTN - 1);
    localparam logic [ID_WIDTH-1:0]  c_ID_ONE    = ID_WIDTH'(1);

    localparam logic [1:0] c_KIND_PRESS   = 2'b00;
    localparam logic [1:0] c_KIND_REPEAT  = 2'b01;
    localparam logic [1:0] c_KIND_RELEASE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Per-button state
    state_t                 r_state     [NUM_BTN];
    logic [CNT_WIDTH-1:0]   r_cnt       [NUM_BTN];
    state_t                 w_state_nxt [NUM_BTN];
    logic [CNT_WIDTH-1:0]   w_cnt_nxt   [NUM_BTN];

    logic [NUM_BTN-1:0]     r_press_pend;
    logic [NUM_BTN-1:0]     r_rep_pend;
    logic [NUM_BTN-1:0]     r_rel_pend;
    logic [NUM_BTN-1:0]     w_set_press;
    logic [NUM_BTN-1:0]     w_set_rep;
    logic [NUM_BTN-1:0]     w_set_rel;
    logic [NUM_BTN-1:0]     w_gnt_press;
    logic [NUM_BTN-1:0]     w_gnt_rep;
    logic [NUM_BTN-1:0]     w_gnt_rel;

    // Arbiter / output
    logic [ID_WIDTH-1:0]    r_ptr;
    logic [NUM_BTN-1:0]     w_has;
    logic [c_SCAN_W-1:0]    w_scan;
    logic                   w_found;
    logic [ID_WIDTH-1:0]    w_win_id;
    logic                   w_win_press;
    logic                   w_win_rep;
    logic [1:0]             w_kind;
    logic [ID_WIDTH-1:0]    w_ptr_nxt;
    logic                   w_load;
    logic                   w_ovf_set;

    logic                   r_evt_valid;
    logic [ID_WIDTH-1:0]    r_evt_id;
    logic [1:0]             r_evt_kind;
    logic                   r_overflow;

    // ------------------------------------------------------------------
    // Per-button hold/repeat state machines (next-state logic).
    // Release is checked first so it wins over a same-cycle expiry.
    // ------------------------------------------------------------------
    always_comb begin
        w_set_press = '0;
        w_set_rep   = '0;
        w_set_rel   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (btn_level[i]) begin
                        w_state_nxt[i] = ST_HOLD;
                        w_cnt_nxt[i]   = '0;
                        w_set_press[i] = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!btn_level[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                        w_set_rel[i]   = 1'b1;
                    end else if (r_cnt[i] == c_HOLD_LAST && repeat_en[i]) begin
                        w_state_nxt[i] = ST_REPEAT;
                        w_cnt_nxt[i]   = '0;
                        w_set_rep[i]   = 1'b1;
                    end else if (r_cnt[i] < c_HOLD_LAST) begin
                        w_cnt_nxt[i]   = r_cnt[i] + c_CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!btn_level[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                        w_set_rel[i]   = 1'b1;
                    end else if (!repeat_en[i]) begin
                        // Park in HOLD already expired so a later enable
                        // repeats on the very next edge.
                        w_state_nxt[i] = ST_HOLD;
                        w_cnt_nxt[i]   = c_HOLD_LAST;
                    end else if (r_cnt[i] == c_REP_LAST) begin
                        w_cnt_nxt[i]   = '0;
                        w_set_rep[i]   = 1'b1;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search starting at r_ptr, wrapping modulo NUM_BTN.
    // ------------------------------------------------------------------
    assign w_has = r_press_pend | r_rep_pend | r_rel_pend;

    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_scan   = '0;
        for (int j = 0; j < NUM_BTN; j++) begin
            w_scan = {1'b0, r_ptr} + c_SCAN_W'(j);
            if (w_scan >= c_NUM_EXT) begin
                w_scan = w_scan - c_NUM_EXT;
            end
            if (!w_found && w_has[w_scan[ID_WIDTH-1:0]]) begin
                w_found  = 1'b1;
                w_win_id = w_scan[ID_WIDTH-1:0];
            end
        end
    end

    assign w_win_press = r_press_pend[w_win_id];
    assign w_win_rep   = r_rep_pend[w_win_id];
    assign w_kind      = w_win_press ? c_KIND_PRESS :
                         w_win_rep   ? c_KIND_REPEAT : c_KIND_RELEASE;
    assign w_ptr_nxt   = (w_win_id == c_LAST_ID) ? '0 : w_win_id + c_ID_ONE;

    // Output register takes a new event when empty or being accepted.
    assign w_load = !r_evt_valid || evt_ready;

    always_comb begin
        w_gnt_press = '0;
        w_gnt_rep   = '0;
        w_gnt_rel   = '0;
        if (w_load && w_found) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_win_id == ID_WIDTH'(i)) begin
                    w_gnt_press[i] = w_win_press;
                    w_gnt_rep[i]   = !w_win_press && w_win_rep;
                    w_gnt_rel[i]   = !w_win_press && !w_win_rep;
                end
            end
        end
    end

    // A new event collides only if its bit is still pending after this
    // cycle; a bit granted in the same cycle simply re-arms.
    assign w_ovf_set = |((w_set_press & r_press_pend & ~w_gnt_press) |
                         (w_set_rep   & r_rep_pend   & ~w_gnt_rep)   |
                         (w_set_rel   & r_rel_pend   & ~w_gnt_rel));

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_press_pend <= '0;
            r_rep_pend   <= '0;
            r_rel_pend   <= '0;
            r_ptr        <= '0;
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_evt_kind   <= c_KIND_PRESS;
            r_overflow   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_press_pend <= w_set_press | (r_press_pend & ~w_gnt_press);
            r_rep_pend   <= w_set_rep   | (r_rep_pend   & ~w_gnt_rep);
            r_rel_pend   <= w_set_rel   | (r_rel_pend   & ~w_gnt_rel);
            r_overflow   <= r_overflow | w_ovf_set;
            if (w_load) begin
                r_evt_valid <= w_found;
                if (w_found) begin
                    r_evt_id   <= w_win_id;
                    r_evt_kind <= w_kind;
                    r_ptr      <= w_ptr_nxt;
                end
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign evt_kind  = r_evt_kind;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_button_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_scheduler
//  Description : Directed self-checking bench for button_event_scheduler with
//                HOLD_CYCLES=8 and REPEAT_CYCLES=4. Accepted events are logged
//                with the edge number at which they became visible and then
//                compared against hand-computed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_scheduler;

    localparam int NB  = 5;
    localparam int IDW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NB-1:0]  btn_level = '0;
    logic [NB-1:0]  repeat_en = '0;
    logic           evt_ready = 1'b0;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic [1:0]     evt_kind;
    logic           overflow;

    button_event_scheduler #(
        .NUM_BTN      (NB),
        .ID_WIDTH     (IDW),
        .CNT_WIDTH    (27),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_level(btn_level),
        .repeat_en(repeat_en),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_kind (evt_kind),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge number e, cyc == e.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int id;
        int kind;
    } ev_t;
    ev_t evq[$];

    // Log every event that will be accepted at the next edge, tagged with
    // the edge after which it became visible.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            evq.push_back('{cyc, int'(evt_id), int'(evt_kind)});
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input int t, input int id, input int kind);
        if (idx < evq.size()) begin
            check({tag, "_time"}, evq[idx].t, t);
            check({tag, "_id"},   evq[idx].id, id);
            check({tag, "_kind"}, evq[idx].kind, kind);
        end else begin
            check({tag, "_missing"}, evq.size(), idx + 1);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    int k;
    int m;
    int exp_id   [6] = '{1, 3, 4, 1, 3, 4};
    int exp_kind [6] = '{0, 0, 0, 2, 2, 2};

    initial begin
        // ---------------- reset state ----------------
        tick(2);
        rst = 1'b0;
        check("rst_valid", evt_valid, 0);
        check("rst_id", evt_id, 0);
        check("rst_kind", evt_kind, 0);
        check("rst_ovf", overflow, 0);

        // ---------------- short press on btn2, no repeat ----------------
        evt_ready = 1'b1;
        evq.delete();
        btn_level[2] = 1'b1;
        k = cyc + 1;
        tick(3);
        btn_level[2] = 1'b0;
        tick(5);
        check("t1_count", evq.size(), 2);
        check_ev("t1_press", 0, k + 1, 2, 0);
        check_ev("t1_rel", 1, k + 4, 2, 2);
        check("t1_ovf", overflow, 0);

        // ---------------- hold with auto-repeat on btn0 ----------------
        repeat_en = '1;
        evq.delete();
        btn_level[0] = 1'b1;
        k = cyc + 1;
        tick(20);
        btn_level[0] = 1'b0;
        tick(4);
        check("t2_count", evq.size(), 5);
        check_ev("t2_press", 0, k + 1, 0, 0);
        check_ev("t2_rep1", 1, k + 9, 0, 1);
        check_ev("t2_rep2", 2, k + 13, 0, 1);
        check_ev("t2_rep3", 3, k + 17, 0, 1);
        check_ev("t2_rel", 4, k + 21, 0, 2);

        // ---------------- simultaneous presses, round robin ----------------
        repeat_en = '0;
        do_reset();
        evq.delete();
        btn_level = 5'b11010;
        k = cyc + 1;
        tick(3);
        btn_level = '0;
        tick(6);
        check("t3_count", evq.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_ev($sformatf("t3_ev%0d", i), i, k + 1 + i, exp_id[i], exp_kind[i]);
        end

        // ---------------- back-pressure and overflow ----------------
        do_reset();
        evt_ready = 1'b0;
        evq.delete();
        btn_level[0] = 1'b1;
        k = cyc + 1;
        tick(1);
        btn_level[0] = 1'b0;
        tick(1);
        btn_level[0] = 1'b1;
        tick(1);
        btn_level[0] = 1'b0;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t4_stable%0d", i), {26'd0, evt_valid, evt_id, evt_kind}, 32'h20);
            tick(1);
        end
        check("t4_ovf", overflow, 1);
        evt_ready = 1'b1;
        tick(4);
        check("t4_count", evq.size(), 3);
        check_ev("t4_held", 0, k + 9, 0, 0);
        check_ev("t4_press", 1, k + 10, 0, 0);
        check_ev("t4_rel", 2, k + 11, 0, 2);

        // ---------------- late repeat enable ----------------
        do_reset();
        evt_ready = 1'b1;
        repeat_en = '0;
        evq.delete();
        btn_level[0] = 1'b1;
        k = cyc + 1;
        tick(12);
        m = cyc;
        repeat_en[0] = 1'b1;
        tick(3);
        check("t5_count", evq.size(), 2);
        check_ev("t5_press", 0, k + 1, 0, 0);
        check_ev("t5_rep", 1, m + 2, 0, 1);
        btn_level = '0;
        repeat_en = '0;
        tick(3);

        // ---------------- reset while busy ----------------
        do_reset();
        evt_ready = 1'b0;
        evq.delete();
        btn_level = 5'b00101;
        k = cyc + 1;
        tick(1);
        btn_level[0] = 1'b0;
        tick(1);
        btn_level[0] = 1'b1;
        tick(1);
        btn_level[0] = 1'b0;
        tick(2);
        check("t6_pre_valid", evt_valid, 1);
        check("t6_pre_ovf", overflow, 1);
        rst = 1'b1;
        tick(1);
        check("t6_post_valid", evt_valid, 0);
        check("t6_post_ovf", overflow, 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        evq.delete();
        tick(4);
        check("t6_count", evq.size(), 1);
        check_ev("t6_press", 0, k + 7, 2, 0);

        btn_level = '0;
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
